// File: rtl/bcd_score_counter_if.sv
// Line-clear event port and score/status outputs of bcd_score_counter.
// The producer side uses master, the counter itself uses slave.
interface bcd_score_counter_if;
    logic       clear_valid;
    logic [2:0] clear_lines;
    logic       ready;
    logic       busy;
    logic       done;
    logic       dropped;
    logic       sat;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] score3;
    logic [3:0] score4;

    modport master (
        output clear_valid, clear_lines,
        input  ready, busy, done, dropped, sat,
        input  score1, score2, score3, score4
    );

    modport slave (
        input  clear_valid, clear_lines,
        output ready, busy, done, dropped, sat,
        output score1, score2, score3, score4
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score accumulator: a line-clear event loads its point value,
// then the score is stepped by one per cycle so the digits are always legal BCD.
module bcd_score_counter #(
    parameter int unsigned PTS1 = 1,
    parameter int unsigned PTS2 = 3,
    parameter int unsigned PTS3 = 5,
    parameter int unsigned PTS4 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_score_counter_if.slave   bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ADD  = 1'b1;

    logic [0:0] state;
    logic [3:0] remaining;
    logic [3:0] d1, d2, d3, d4;
    logic       done_r, dropped_r, sat_r;

    logic       lines_ok;
    logic [3:0] pts_sel;
    logic [3:0] inc1, inc2, inc3, inc4;
    logic       c1, c2, c3, at_max, will_max;

    always_comb begin
        lines_ok = (bus.clear_lines != 3'd0) && (bus.clear_lines <= 3'd4);
        pts_sel  = 4'd0;
        case (bus.clear_lines)
            3'd1:    pts_sel = 4'(PTS1);
            3'd2:    pts_sel = 4'(PTS2);
            3'd3:    pts_sel = 4'(PTS3);
            3'd4:    pts_sel = 4'(PTS4);
            default: pts_sel = 4'd0;
        endcase
    end

    // Ripple the +1 through all four digits in a single cycle.
    always_comb begin
        c1       = (d1 == 4'd9);
        c2       = c1 && (d2 == 4'd9);
        c3       = c2 && (d3 == 4'd9);
        at_max   = c3 && (d4 == 4'd9);
        inc1     = c1 ? 4'd0 : d1 + 4'd1;
        inc2     = c1 ? ((d2 == 4'd9) ? 4'd0 : d2 + 4'd1) : d2;
        inc3     = c2 ? ((d3 == 4'd9) ? 4'd0 : d3 + 4'd1) : d3;
        inc4     = c3 ? ((d4 == 4'd9) ? 4'd0 : d4 + 4'd1) : d4;
        will_max = (inc1 == 4'd9) && (inc2 == 4'd9) && (inc3 == 4'd9) && (inc4 == 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 4'd0;
            d1        <= 4'd0;
            d2        <= 4'd0;
            d3        <= 4'd0;
            d4        <= 4'd0;
            done_r    <= 1'b0;
            dropped_r <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear_valid && lines_ok) begin
                        remaining <= pts_sel;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    if (bus.clear_valid && lines_ok)
                        dropped_r <= 1'b1;
                    // At 9999 the value holds; the countdown and done still proceed.
                    if (at_max) begin
                        sat_r <= 1'b1;
                    end else begin
                        d1 <= inc1;
                        d2 <= inc2;
                        d3 <= inc3;
                        d4 <= inc4;
                        if (will_max)
                            sat_r <= 1'b1;
                    end
                    remaining <= remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ADD);
    assign bus.ready   = (state != ADD);
    assign bus.done    = done_r;
    assign bus.dropped = dropped_r;
    assign bus.sat     = sat_r;
    assign bus.score1  = d1;
    assign bus.score2  = d2;
    assign bus.score3  = d3;
    assign bus.score4  = d4;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Self-checking bench for bcd_score_counter: directed scenarios plus random
// line-clear pulses compared against an integer score model.
module tb_bcd_score_counter;

    logic clk;
    logic rst;

    bcd_score_counter_if bus ();

    bcd_score_counter #(
        .PTS1(1), .PTS2(3), .PTS3(5), .PTS4(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int pts_tab[5] = '{0, 1, 3, 5, 8};

    // Reference model: whole score as an integer plus the points still owed.
    int m_score;
    int m_pending;
    int m_done;
    int m_dropped;
    int m_sat;
    int m_accepted;

    function automatic int dut_score();
        return int'(bus.score4) * 1000 + int'(bus.score3) * 100 +
               int'(bus.score2) * 10 + int'(bus.score1);
    endfunction

    task automatic model_edge(input logic v, input logic [2:0] l, input logic r);
        bit lines_ok;
        lines_ok = (l >= 3'd1) && (l <= 3'd4);
        if (r) begin
            m_score = 0; m_pending = 0; m_done = 0; m_dropped = 0; m_sat = 0;
        end else begin
            m_done = 0;
            if (m_pending == 0) begin
                if (v && lines_ok) begin
                    m_pending = pts_tab[l];
                    m_accepted++;
                end
            end else begin
                if (v && lines_ok) m_dropped = 1;
                if (m_score < 9999) m_score++;
                if (m_score == 9999) m_sat = 1;
                m_pending--;
                if (m_pending == 0) m_done = 1;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [2:0] l, input logic r);
        bus.clear_valid = v;
        bus.clear_lines = l;
        rst             = r;
        @(posedge clk);
        model_edge(v, l, r);
        #1;
        bus.clear_valid = 1'b0;
        rst             = 1'b0;
    endtask

    task automatic load_to(input int target);
        int diff;
        int guard;
        logic [2:0] l;
        guard = 0;
        while (m_score < target && guard < 20000) begin
            diff = target - m_score;
            if (diff >= 8)      l = 3'd4;
            else if (diff >= 5) l = 3'd3;
            else if (diff >= 3) l = 3'd2;
            else                l = 3'd1;
            tick(1'b1, l, 1'b0);
            guard++;
            while (m_pending > 0 && guard < 20000) begin
                tick(1'b0, 3'd0, 1'b0);
                guard++;
            end
        end
        checks++;
        if (dut_score() !== target || guard >= 20000) begin
            failures++;
            $display("[TB] FAIL load_to: score=%0d required=%0d guard=%0d", dut_score(), target, guard);
        end
    endtask

    task automatic test_reset();
        tick(1'b0, 3'd0, 1'b1);
        checks++;
        if (dut_score() !== 0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 ||
            bus.done !== 1'b0 || bus.dropped !== 1'b0 || bus.sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: score=%0d busy=%b ready=%b done=%b dropped=%b sat=%b required 0/0/1/0/0/0",
                     dut_score(), bus.busy, bus.ready, bus.done, bus.dropped, bus.sat);
        end
    endtask

    task automatic test_one_line();
        tick(1'b0, 3'd0, 1'b1);
        tick(1'b1, 3'd1, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || dut_score() !== 0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL one_line_accept: busy=%b ready=%b score=%0d done=%b required 1/0/0/0",
                     bus.busy, bus.ready, dut_score(), bus.done);
        end
        tick(1'b0, 3'd0, 1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || dut_score() !== 1 || bus.done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL one_line_final: busy=%b ready=%b score=%0d done=%b required 0/1/1/1",
                     bus.busy, bus.ready, dut_score(), bus.done);
        end
        tick(1'b0, 3'd0, 1'b0);
        checks++;
        if (bus.done !== 1'b0 || dut_score() !== 1) begin
            failures++;
            $display("[TB] FAIL one_line_done_once: done=%b score=%0d required 0/1", bus.done, dut_score());
        end
    endtask

    task automatic test_carry();
        int busy_cycles;
        tick(1'b0, 3'd0, 1'b1);
        load_to(95);
        tick(1'b1, 3'd4, 1'b0);
        busy_cycles = 0;
        for (int i = 1; i <= 8; i++) begin
            busy_cycles += (bus.busy === 1'b1) ? 1 : 0;
            tick(1'b0, 3'd0, 1'b0);
            checks++;
            if (dut_score() !== 95 + i || bus.done !== (i == 8)) begin
                failures++;
                $display("[TB] FAIL carry_step%0d: score=%0d done=%b required %0d/%0d",
                         i, dut_score(), bus.done, 95 + i, (i == 8));
            end
        end
        checks++;
        if (busy_cycles !== 8 || bus.busy !== 1'b0 || bus.score3 !== 4'd1 ||
            bus.score2 !== 4'd0 || bus.score1 !== 4'd3 || bus.score4 !== 4'd0) begin
            failures++;
            $display("[TB] FAIL carry_final: busy_cycles=%0d busy=%b digits=%0d%0d%0d%0d required 8/0/0103",
                     busy_cycles, bus.busy, bus.score4, bus.score3, bus.score2, bus.score1);
        end
    endtask

    task automatic test_drop();
        tick(1'b0, 3'd0, 1'b1);
        tick(1'b1, 3'd3, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        tick(1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 3'd0, 1'b0);
        checks++;
        if (dut_score() !== 5 || bus.dropped !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_busy: score=%0d dropped=%b busy=%b required 5/1/0",
                     dut_score(), bus.dropped, bus.busy);
        end
        tick(1'b0, 3'd0, 1'b1);
        tick(1'b1, 3'd0, 1'b0);
        checks++;
        if (dut_score() !== 0 || bus.busy !== 1'b0 || bus.dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_lines0: score=%0d busy=%b dropped=%b required 0/0/0",
                     dut_score(), bus.busy, bus.dropped);
        end
        tick(1'b1, 3'd6, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        checks++;
        if (dut_score() !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_lines6: score=%0d busy=%b done=%b required 0/0/0",
                     dut_score(), bus.busy, bus.done);
        end
    endtask

    task automatic test_saturation();
        tick(1'b0, 3'd0, 1'b1);
        load_to(9995);
        checks++;
        if (bus.sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_before: sat=%b required 0", bus.sat);
        end
        tick(1'b1, 3'd4, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 3'd0, 1'b0);
            checks++;
            if (bus.done !== (i == 8) || dut_score() !== ((95 + i > 99) ? 9999 : 9900 + 95 + i)) begin
                failures++;
                $display("[TB] FAIL sat_step%0d: score=%0d done=%b required %0d/%0d", i, dut_score(),
                         bus.done, (95 + i > 99) ? 9999 : 9900 + 95 + i, (i == 8));
            end
        end
        checks++;
        if (dut_score() !== 9999 || bus.sat !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_final: score=%0d sat=%b busy=%b required 9999/1/0",
                     dut_score(), bus.sat, bus.busy);
        end
    endtask

    task automatic test_reset_mid_add();
        int done_seen;
        tick(1'b0, 3'd0, 1'b1);
        tick(1'b1, 3'd4, 1'b0);
        tick(1'b1, 3'd1, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        checks++;
        if (bus.dropped !== 1'b1 || dut_score() !== 2) begin
            failures++;
            $display("[TB] FAIL mid_add_setup: dropped=%b score=%0d required 1/2", bus.dropped, dut_score());
        end
        tick(1'b0, 3'd0, 1'b1);
        checks++;
        if (dut_score() !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.dropped !== 1'b0 || bus.sat !== 1'b0 || bus.ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_add_reset: score=%0d busy=%b done=%b dropped=%b sat=%b ready=%b required 0/0/0/0/0/1",
                     dut_score(), bus.busy, bus.done, bus.dropped, bus.sat, bus.ready);
        end
        tick(1'b1, 3'd2, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 3'd0, 1'b0);
            done_seen += (bus.done === 1'b1) ? 1 : 0;
        end
        checks++;
        if (dut_score() !== 0 || bus.busy !== 1'b0 || done_seen !== 0) begin
            failures++;
            $display("[TB] FAIL reset_priority: score=%0d busy=%b done_pulses=%0d required 0/0/0",
                     dut_score(), bus.busy, done_seen);
        end
    endtask

    task automatic test_random();
        int gap;
        int dut_done_cnt;
        int start_accepted;
        int guard;
        logic [2:0] l;
        tick(1'b0, 3'd0, 1'b1);
        dut_done_cnt   = 0;
        start_accepted = m_accepted;
        for (int p = 0; p < 1000; p++) begin
            gap = $urandom_range(0, 3);
            for (int c = 0; c <= gap; c++) begin
                l = 3'($urandom_range(0, 7));
                tick((c == 0), l, 1'b0);
                dut_done_cnt += (bus.done === 1'b1) ? 1 : 0;
                checks++;
                if (dut_score() !== m_score || bus.busy !== (m_pending > 0) ||
                    bus.done !== m_done[0] || bus.dropped !== m_dropped[0] || bus.sat !== m_sat[0] ||
                    bus.score1 > 4'd9 || bus.score2 > 4'd9 || bus.score3 > 4'd9 || bus.score4 > 4'd9) begin
                    failures++;
                    $display("[TB] FAIL random_p%0d: score=%0d busy=%b done=%b dropped=%b sat=%b required %0d/%0d/%0d/%0d/%0d",
                             p, dut_score(), bus.busy, bus.done, bus.dropped, bus.sat,
                             m_score, (m_pending > 0), m_done, m_dropped, m_sat);
                end
            end
        end
        guard = 0;
        while (m_pending > 0 && guard < 20) begin
            tick(1'b0, 3'd0, 1'b0);
            dut_done_cnt += (bus.done === 1'b1) ? 1 : 0;
            guard++;
        end
        checks++;
        if (dut_done_cnt !== m_accepted - start_accepted || dut_score() !== m_score) begin
            failures++;
            $display("[TB] FAIL random_done_count: done_pulses=%0d score=%0d required %0d/%0d",
                     dut_done_cnt, dut_score(), m_accepted - start_accepted, m_score);
        end
    endtask

    initial begin
        bus.clear_valid = 1'b0;
        bus.clear_lines = 3'd0;
        rst             = 1'b1;
        m_score = 0; m_pending = 0; m_done = 0; m_dropped = 0; m_sat = 0; m_accepted = 0;
        @(negedge clk);
        test_reset();
        test_one_line();
        test_carry();
        test_drop();
        test_saturation();
        test_reset_mid_add();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
